bk_memctl: RTL and testbench
============================

# bk_memctl

Memory responder for the BK-0010 core bus. It accepts the core's `rd`/`wt`/`adr`/`byte`/write-data strobes, runs timed cycles on a 16-bit asynchronous SRAM, and returns read data plus a reply handshake. It also serves single-word video fetches from the screen area, interleaving them with CPU accesses. It sits between the core and the board SRAM pins.

## Interface
Parameters:
- `WAIT`, default 2: SRAM strobe length in `clk` cycles, legal range 1..15.

Ports:
- `clk` in 1: single clock; everything is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_rd` in 1: core read strobe, level, held until reply.
- `cpu_wt` in 1: core write strobe, level, held until reply.
- `cpu_byte` in 1: byte access.
- `cpu_adr` in 16: byte address.
- `cpu_data_i` in 16: write data. For odd-byte writes the core has already replicated the byte to both lanes.
- `cpu_data_o` out 16: read data, full SRAM word. The core does its own lane selection.
- `cpu_reply` out 1: reply to the core.
- `vid_req` in 1: one-cycle video fetch request.
- `vid_adr` in 13: word offset within the 16 KB screen.
- `vid_data` out 16: fetched video word.
- `vid_valid` out 1: one-cycle pulse when `vid_data` is updated.
- `vid_ovr` out 1: one-cycle pulse when a pending video request is overwritten.
- `sram_a` out 18: SRAM word address.
- `sram_d_i` in 16: SRAM data in.
- `sram_d_o` out 16: SRAM data out.
- `sram_d_oe` out 1: SRAM data output enable.
- `sram_we_n` out 1, `sram_oe_n` out 1, `sram_ub_n` out 1, `sram_lb_n` out 1: SRAM controls, active low.

## Operation
- **Address map.**
  - CPU accesses use `sram_a = {3'b000, cpu_adr[15:1]}`. ROM space (`cpu_adr[15]=1`) is preloaded SRAM. The core never issues `wt` there.
  - Video accesses use `sram_a = {5'b00001, vid_adr}`, i.e. byte 040000 and up.
- **Byte lanes.**
  - Reads, CPU or video: `ub_n = lb_n = 0`.
  - Word write: both lanes low.
  - Byte write: `lb_n = cpu_adr[0]`, `ub_n = ~cpu_adr[0]`.
- **Request capture.**
  - CPU request = `(cpu_rd|cpu_wt) & ~served`.
  - `served` sets when `cpu_reply` rises and clears in the cycle after both strobes are low.
  - `vid_req` is latched into a one-deep pending register (address plus flag). A new `vid_req` while one is pending replaces the address and pulses `vid_ovr`.
- **FSM states:** IDLE, SETUP, STROBE, HOLD, REPLY.
  - IDLE → SETUP when either request is present. If both are present, video wins. The owner (CPU/VID) and the direction are registered at this transition.
  - SETUP: 1 cycle. Address and lanes are driven. For a read, `oe_n=0`. For a write, `d_oe=1` and `d_o=cpu_data_i` (registered).
  - STROBE: `WAIT` cycles, counted by a 4-bit counter. Write: `we_n=0`. Read: `oe_n=0`, and `sram_d_i` is registered into `cpu_data_o` or `vid_data` on the last STROBE cycle.
  - HOLD: 1 cycle. `we_n=1`, while address, data and `d_oe` stay stable. For a video access, `vid_valid` pulses in this cycle and the next state is IDLE. For a CPU access the next state is REPLY.
  - REPLY: `cpu_reply=1`. Stay while `cpu_rd|cpu_wt`. Go to IDLE in the cycle after the strobes drop, with `cpu_reply=0` in that same IDLE cycle.
- **Boundary conditions.**
  - Both `cpu_rd` and `cpu_wt` high: treat as a write.
  - CPU strobe dropped before HOLD: the SRAM cycle completes, REPLY is skipped, and `served` stays clear.
  - A video request arriving during a CPU access waits in the pending register and is served at the next IDLE, ahead of any new CPU request.
  - `cpu_data_o` holds its value until the next CPU read completes. Writes do not alter it.
- **Reset (asynchronous, at any time including mid-cycle).** State goes to IDLE; pending and `served` clear. Output values under reset:
  - `sram_we_n`, `sram_oe_n`, `sram_ub_n`, `sram_lb_n` = 1.
  - `sram_d_oe`, `cpu_reply`, `vid_valid`, `vid_ovr` = 0.
  - `sram_a`, `sram_d_o`, `cpu_data_o`, `vid_data` = 0.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- CPU request first visible in IDLE at cycle n:
  - SETUP at n+1.
  - STROBE at n+2 … n+1+WAIT.
  - HOLD at n+2+WAIT.
  - `cpu_reply` high from n+3+WAIT.
  - With WAIT=2, reply comes 5 cycles after the strobe.
- Video request, `vid_req` at cycle n with the FSM idle: `vid_valid` at n+3+WAIT.
- Worst-case video latency is one full CPU access plus its own: 2·WAIT+6 cycles, assuming the CPU drops its strobe immediately.
- Write data and address are stable from SETUP through HOLD inclusive. `we_n` is never low in the SETUP or HOLD cycles.
- Turnaround: at least one IDLE cycle between consecutive SRAM accesses, so `d_oe` falls before any `oe_n` falls.

## Test plan
- **Word read.** Preload SRAM[0x0100]=0x1234. Assert `cpu_rd` at `adr`=0x0200, word. Require `sram_a`=0x00100, `cpu_data_o`=0x1234, and `cpu_reply` high 5 cycles after the strobe (WAIT=2). Reply drops 1 cycle after `rd` falls.
- **Byte write, odd address.** `cpu_wt`, `adr`=0x0201, byte, data=0xABAB. Require `ub_n`=0, `lb_n`=1, `we_n` low for exactly 2 cycles, and SRAM[0x0100]=0xAB34 afterwards.
- **Simultaneous requests.** Pulse `vid_req` (`vid_adr`=0x0005) in the same cycle `cpu_rd` rises. Require the video access first at `sram_a`=0x02005, then `vid_valid`, then the CPU access, with `cpu_reply` at cycle 11.
- **Overrun.** Issue two `vid_req` during a CPU access with addresses 1 and 2. Require `vid_ovr` to pulse once and only `sram_a`=0x02002 to be fetched.
- **Held strobe.** Keep `cpu_rd` high for 20 cycles after reply. Require exactly one SRAM access and `cpu_reply` continuously high.
- **Reset mid-write.** Assert `reset` in STROBE with `we_n`=0. Require `we_n`=1, `d_oe`=0 and `reply`=0 immediately. After release, the next request starts at SETUP.

Source files
------------

// File: rtl/bk_memctl.sv
// BK-0010 core bus to asynchronous 16-bit SRAM responder, with single-word
// video fetches from the screen area interleaved between CPU accesses.
module bk_memctl #(
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rd,
  input  logic        cpu_wt,
  input  logic        cpu_byte,
  input  logic [15:0] cpu_adr,
  input  logic [15:0] cpu_data_i,
  output logic [15:0] cpu_data_o,
  output logic        cpu_reply,
  input  logic        vid_req,
  input  logic [12:0] vid_adr,
  output logic [15:0] vid_data,
  output logic        vid_valid,
  output logic        vid_ovr,
  output logic [17:0] sram_a,
  input  logic [15:0] sram_d_i,
  output logic [15:0] sram_d_o,
  output logic        sram_d_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, REPLY} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        served;
  logic        pend_valid;
  logic [12:0] pend_adr;
  logic        own_vid;
  logic        is_wr;
  logic        byte_wr;
  logic        odd;
  logic        cpu_act;
  logic        cpu_req;
  logic        start_vid;
  logic        start_cpu;
  logic        last_strobe;

  assign cpu_act     = cpu_rd | cpu_wt;
  assign cpu_req     = cpu_act & ~served;
  assign start_vid   = (state == IDLE) && pend_valid;
  // A fresh vid_req holds the CPU off for one cycle so video still wins a tie.
  assign start_cpu   = (state == IDLE) && !pend_valid && !vid_req && cpu_req;
  assign last_strobe = (state == STROBE) && (cnt == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_vid || start_cpu) next_state = SETUP;
      SETUP:   next_state = STROBE;
      STROBE:  if (cnt == 4'd0) next_state = HOLD;
      HOLD:    next_state = (own_vid || !cpu_act) ? IDLE : REPLY;
      REPLY:   if (!cpu_act) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_ub_n = 1'b1;
    sram_lb_n = 1'b1;
    sram_d_oe = 1'b0;
    cpu_reply = 1'b0;
    vid_valid = 1'b0;
    if (state == SETUP || state == STROBE || state == HOLD) begin
      sram_ub_n = is_wr & byte_wr & ~odd;
      sram_lb_n = is_wr & byte_wr & odd;
      sram_d_oe = is_wr;
    end
    case (state)
      SETUP:   sram_oe_n = is_wr;
      STROBE: begin
        sram_oe_n = is_wr;
        sram_we_n = ~is_wr;
      end
      HOLD:    vid_valid = own_vid;
      REPLY:   cpu_reply = 1'b1;
      default: ;
    endcase
  end

  // Access attributes, address and write data are frozen at IDLE->SETUP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= 4'd0;
      own_vid    <= 1'b0;
      is_wr      <= 1'b0;
      byte_wr    <= 1'b0;
      odd        <= 1'b0;
      sram_a     <= 18'd0;
      sram_d_o   <= 16'd0;
      cpu_data_o <= 16'd0;
      vid_data   <= 16'd0;
      pend_valid <= 1'b0;
      pend_adr   <= 13'd0;
      vid_ovr    <= 1'b0;
      served     <= 1'b0;
    end else begin
      if (state == SETUP)
        cnt <= 4'(WAIT - 1);
      else if (state == STROBE && cnt != 4'd0)
        cnt <= cnt - 4'd1;

      if (start_vid) begin
        own_vid <= 1'b1;
        is_wr   <= 1'b0;
        byte_wr <= 1'b0;
        odd     <= 1'b0;
        sram_a  <= {5'b00001, pend_adr};
      end else if (start_cpu) begin
        own_vid <= 1'b0;
        is_wr   <= cpu_wt;
        byte_wr <= cpu_byte;
        odd     <= cpu_adr[0];
        sram_a  <= {3'b000, cpu_adr[15:1]};
        if (cpu_wt) sram_d_o <= cpu_data_i;
      end

      vid_ovr <= 1'b0;
      if (vid_req) begin
        pend_valid <= 1'b1;
        pend_adr   <= vid_adr;
        if (pend_valid && !start_vid) vid_ovr <= 1'b1;
      end else if (start_vid) begin
        pend_valid <= 1'b0;
      end

      if (last_strobe && !is_wr) begin
        if (own_vid) vid_data   <= sram_d_i;
        else         cpu_data_o <= sram_d_i;
      end

      if (state == HOLD && next_state == REPLY) served <= 1'b1;
      else if (!cpu_act)                         served <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bk_memctl.sv
// Self-checking bench for bk_memctl: SRAM model, table vectors, randomized
// traffic against a word-array reference, and multi-cycle corner sequences.
module tb_bk_memctl;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wt, cpu_byte;
  logic [15:0] cpu_adr, cpu_data_i, cpu_data_o;
  logic        cpu_reply;
  logic        vid_req;
  logic [12:0] vid_adr;
  logic [15:0] vid_data;
  logic        vid_valid, vid_ovr;
  logic [17:0] sram_a;
  logic [15:0] sram_d_i, sram_d_o;
  logic        sram_d_oe, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;

  bk_memctl #(.WAIT(WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wt(cpu_wt), .cpu_byte(cpu_byte), .cpu_adr(cpu_adr),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_reply(cpu_reply),
    .vid_req(vid_req), .vid_adr(vid_adr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_ovr(vid_ovr),
    .sram_a(sram_a), .sram_d_i(sram_d_i), .sram_d_o(sram_d_o), .sram_d_oe(sram_d_oe),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] initVal(int i);
    return 16'(i) ^ 16'h5A5A;
  endfunction

  // Board SRAM: asynchronous read, lane-masked write while we_n is low.
  logic [15:0] mem [0:32767];
  logic        mem_ready = 1'b0;
  assign sram_d_i = mem[sram_a[14:0]];
  always @(posedge clk) begin
    if (reset && !mem_ready) begin
      for (int i = 0; i < 32768; i++) mem[i] <= initVal(i);
      mem_ready <= 1'b1;
    end else if (!sram_we_n) begin
      if (!sram_lb_n) mem[sram_a[14:0]][7:0]  <= sram_d_o[7:0];
      if (!sram_ub_n) mem[sram_a[14:0]][15:8] <= sram_d_o[15:8];
    end
  end

  // Bus monitor: access starts, overrun pulses, and drive-conflict counts.
  int          ovr_cnt = 0;
  int          viol = 0;
  logic        prev_act = 1'b0;
  logic [19:0] acc_q[$];
  always @(negedge clk) begin
    if (vid_ovr) ovr_cnt++;
    if (!sram_we_n && !sram_d_oe) viol++;
    if (sram_d_oe && !sram_oe_n) viol++;
    if ((!sram_we_n || !sram_oe_n) && !prev_act) acc_q.push_back({sram_ub_n, sram_lb_n, sram_a});
    prev_act = !sram_we_n || !sram_oe_n;
  end

  logic [15:0] ref_mem [0:32767];
  int tests = 0;
  int failed = 0;

  typedef struct {
    logic        rd, wt, byt;
    logic [15:0] adr, data;
    logic [17:0] exp_a;
    logic        exp_ub, exp_lb;
    logic [15:0] exp_do;
  } vec_t;
  vec_t vecs[11];

  task automatic setVec(input int i, input logic rd, wt, byt, input logic [15:0] adr, data,
                        input logic [17:0] a, input logic ub, lb, input logic [15:0] dout);
    vecs[i].rd = rd; vecs[i].wt = wt; vecs[i].byt = byt;
    vecs[i].adr = adr; vecs[i].data = data; vecs[i].exp_a = a;
    vecs[i].exp_ub = ub; vecs[i].exp_lb = lb; vecs[i].exp_do = dout;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void modelWrite(logic byt, logic [15:0] adr, logic [15:0] data);
    if (!byt)        ref_mem[adr[15:1]]       = data;
    else if (adr[0]) ref_mem[adr[15:1]][15:8] = data[15:8];
    else             ref_mem[adr[15:1]][7:0]  = data[7:0];
  endfunction

  function automatic logic [19:0] accAt(int idx);
    return (idx < acc_q.size()) ? acc_q[idx] : 20'hFFFFF;
  endfunction

  // One complete CPU transaction; holds the strobe `hold` cycles past reply.
  task automatic applyStimulus(input logic rd, wt, byt, input logic [15:0] adr, data,
                               input int hold, output int lat, output logic [19:0] acc,
                               output int nacc, output int wec, output int drops);
    int q0;
    q0 = acc_q.size();
    lat = 0; wec = 0; drops = 0;
    cpu_rd = rd; cpu_wt = wt; cpu_byte = byt; cpu_adr = adr; cpu_data_i = data;
    while (!cpu_reply && lat < 40) begin
      step();
      lat++;
      if (!sram_we_n) wec++;
    end
    repeat (hold) begin
      step();
      if (!cpu_reply) drops++;
    end
    cpu_rd = 1'b0; cpu_wt = 1'b0;
    step();
    checkOutput("reply_release", 32'(cpu_reply), 32'd0);
    nacc = acc_q.size() - q0;
    acc  = accAt(q0);
    if (wt) modelWrite(byt, adr, data);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, nacc, wec, drops, q0, o0, t, vseen, nvid, seen;
    logic [19:0] acc;
    logic [15:0] adr, data, last_rd, vd;
    logic [12:0] va;
    logic        byt;

    for (int i = 0; i < 32768; i++) ref_mem[i] = initVal(i);
    reset = 1'b1; cpu_rd = 0; cpu_wt = 0; cpu_byte = 0; cpu_adr = 0; cpu_data_i = 0;
    vid_req = 0; vid_adr = 0;
    repeat (3) step();
    checkOutput("rst_strobes_n", 32'({sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}), 32'hF);
    checkOutput("rst_flags", 32'({sram_d_oe, cpu_reply, vid_valid, vid_ovr}), 32'h0);
    checkOutput("rst_sram_a", 32'(sram_a), 32'h0);
    checkOutput("rst_sram_d_o", 32'(sram_d_o), 32'h0);
    checkOutput("rst_cpu_data_o", 32'(cpu_data_o), 32'h0);
    checkOutput("rst_vid_data", 32'(vid_data), 32'h0);
    reset = 1'b0;
    step(); step();

    setVec(0,  0, 1, 0, 16'h0200, 16'h1234, 18'h00100, 0, 0, 16'h0000);
    setVec(1,  1, 0, 0, 16'h0200, 16'h0000, 18'h00100, 0, 0, 16'h1234);
    setVec(2,  0, 1, 1, 16'h0201, 16'hABAB, 18'h00100, 0, 1, 16'h1234);
    setVec(3,  1, 0, 0, 16'h0200, 16'h0000, 18'h00100, 0, 0, 16'hAB34);
    setVec(4,  0, 1, 1, 16'h0200, 16'h77CD, 18'h00100, 1, 0, 16'hAB34);
    setVec(5,  1, 0, 1, 16'h0201, 16'h0000, 18'h00100, 0, 0, 16'hABCD);
    setVec(6,  0, 1, 0, 16'h1000, 16'hBEEF, 18'h00800, 0, 0, 16'hABCD);
    setVec(7,  1, 0, 0, 16'h1000, 16'h0000, 18'h00800, 0, 0, 16'hBEEF);
    setVec(8,  1, 0, 0, 16'h8000, 16'h0000, 18'h04000, 0, 0, 16'h1A5A);
    setVec(9,  1, 1, 0, 16'h1002, 16'h5555, 18'h00801, 0, 0, 16'h1A5A);
    setVec(10, 1, 0, 0, 16'h1002, 16'h0000, 18'h00801, 0, 0, 16'h5555);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wt, vecs[i].byt, vecs[i].adr, vecs[i].data, 0,
                    lat, acc, nacc, wec, drops);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(WAIT + 3));
      checkOutput($sformatf("vec%0d_accesses", i), 32'(nacc), 32'd1);
      checkOutput($sformatf("vec%0d_sram_a", i), 32'(acc[17:0]), 32'(vecs[i].exp_a));
      checkOutput($sformatf("vec%0d_lanes", i), 32'(acc[19:18]), 32'({vecs[i].exp_ub, vecs[i].exp_lb}));
      checkOutput($sformatf("vec%0d_we_cycles", i), 32'(wec), vecs[i].wt ? 32'(WAIT) : 32'd0);
      checkOutput($sformatf("vec%0d_data_o", i), 32'(cpu_data_o), 32'(vecs[i].exp_do));
    end

    last_rd = 16'h5555;
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 2))
        0: begin
          adr = 16'($urandom);
          byt = 1'($urandom_range(0, 1));
          applyStimulus(1, 0, byt, adr, 16'h0, 0, lat, acc, nacc, wec, drops);
          last_rd = ref_mem[adr[15:1]];
          checkOutput($sformatf("rnd%0d_rd_latency", k), 32'(lat), 32'(WAIT + 3));
          checkOutput($sformatf("rnd%0d_rd_data", k), 32'(cpu_data_o), 32'(last_rd));
        end
        1: begin
          adr  = 16'($urandom) & 16'h7FFF;
          byt  = 1'($urandom_range(0, 1));
          data = 16'($urandom);
          if (byt && adr[0]) data = {data[15:8], data[15:8]};
          applyStimulus(0, 1, byt, adr, data, 0, lat, acc, nacc, wec, drops);
          checkOutput($sformatf("rnd%0d_wr_latency", k), 32'(lat), 32'(WAIT + 3));
          checkOutput($sformatf("rnd%0d_wr_keeps_data_o", k), 32'(cpu_data_o), 32'(last_rd));
        end
        default: begin
          va = 13'($urandom);
          vid_adr = va; vid_req = 1'b1;
          step();
          vid_req = 1'b0;
          lat = 1;
          while (!vid_valid && lat < 40) begin
            step();
            lat++;
          end
          checkOutput($sformatf("rnd%0d_vid_latency", k), 32'(lat), 32'(WAIT + 3));
          checkOutput($sformatf("rnd%0d_vid_data", k), 32'(vid_data), 32'(ref_mem[15'h2000 + 15'(va)]));
          step();
        end
      endcase
    end

    // Video and CPU requests in the same cycle: video first, reply at cycle 11.
    q0 = acc_q.size(); vseen = -1; vd = 16'h0; t = 0;
    vid_adr = 13'h0005; vid_req = 1'b1;
    cpu_rd = 1'b1; cpu_byte = 1'b0; cpu_adr = 16'h0200;
    while (!cpu_reply && t < 40) begin
      step();
      t++;
      vid_req = 1'b0;
      if (vid_valid) begin vseen = t; vd = vid_data; end
    end
    checkOutput("simul_vid_valid_cycle", 32'(vseen), 32'd5);
    checkOutput("simul_vid_data", 32'(vd), 32'(ref_mem[15'h2005]));
    checkOutput("simul_reply_cycle", 32'(t), 32'd11);
    checkOutput("simul_first_addr", 32'(accAt(q0) & 20'h3FFFF), 32'h02005);
    checkOutput("simul_second_addr", 32'(accAt(q0 + 1) & 20'h3FFFF), 32'h00100);
    checkOutput("simul_cpu_data", 32'(cpu_data_o), 32'(ref_mem[15'h0100]));
    cpu_rd = 1'b0;
    step(); step();

    // Two video requests during one CPU access: one overrun, only the last fetched.
    q0 = acc_q.size(); o0 = ovr_cnt; vd = 16'h0;
    cpu_rd = 1'b1; cpu_adr = 16'h0400;
    step(); step();
    vid_adr = 13'h0001; vid_req = 1'b1;
    step();
    vid_adr = 13'h0002;
    step();
    vid_req = 1'b0;
    t = 0;
    while (!cpu_reply && t < 40) begin step(); t++; end
    cpu_rd = 1'b0;
    t = 0;
    while (!vid_valid && t < 40) begin step(); t++; end
    vd = vid_data;
    step(); step();
    nvid = 0;
    for (int i = q0; i < acc_q.size(); i++)
      if (acc_q[i][17:13] == 5'b00001) nvid++;
    checkOutput("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    checkOutput("ovr_video_fetches", 32'(nvid), 32'd1);
    checkOutput("ovr_fetch_addr", 32'(accAt(q0 + 1) & 20'h3FFFF), 32'h02002);
    checkOutput("ovr_vid_data", 32'(vd), 32'(ref_mem[15'h2002]));

    // Strobe held 20 cycles past reply.
    applyStimulus(1, 0, 0, 16'h0200, 16'h0, 20, lat, acc, nacc, wec, drops);
    checkOutput("held_accesses", 32'(nacc), 32'd1);
    checkOutput("held_reply_drops", 32'(drops), 32'd0);
    checkOutput("held_data", 32'(cpu_data_o), 32'(ref_mem[15'h0100]));

    // Strobe dropped before HOLD: no reply, and the next request is not blocked.
    q0 = acc_q.size(); seen = 0;
    cpu_rd = 1'b1; cpu_adr = 16'h0202;
    step(); step();
    cpu_rd = 1'b0;
    repeat (8) begin
      step();
      if (cpu_reply) seen++;
    end
    checkOutput("early_drop_reply", 32'(seen), 32'd0);
    checkOutput("early_drop_accesses", 32'(acc_q.size() - q0), 32'd1);
    applyStimulus(1, 0, 0, 16'h0202, 16'h0, 0, lat, acc, nacc, wec, drops);
    checkOutput("early_drop_next_latency", 32'(lat), 32'(WAIT + 3));
    checkOutput("early_drop_next_data", 32'(cpu_data_o), 32'(ref_mem[15'h0101]));

    // Reset asserted while we_n is low.
    cpu_wt = 1'b1; cpu_byte = 1'b0; cpu_adr = 16'h0600; cpu_data_i = 16'h1111;
    step(); step();
    checkOutput("rst_mid_we_before", 32'(sram_we_n), 32'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid_we_n", 32'(sram_we_n), 32'd1);
    checkOutput("rst_mid_d_oe", 32'(sram_d_oe), 32'd0);
    checkOutput("rst_mid_reply", 32'(cpu_reply), 32'd0);
    checkOutput("rst_mid_sram_a", 32'(sram_a), 32'd0);
    cpu_wt = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    cpu_rd = 1'b1; cpu_adr = 16'h0100;
    step();
    checkOutput("post_rst_setup_oe_n", 32'(sram_oe_n), 32'd0);
    checkOutput("post_rst_setup_addr", 32'(sram_a), 32'h00080);
    t = 1;
    while (!cpu_reply && t < 40) begin step(); t++; end
    checkOutput("post_rst_latency", 32'(t), 32'(WAIT + 3));
    checkOutput("post_rst_data", 32'(cpu_data_o), 32'(ref_mem[15'h0080]));
    checkOutput("post_rst_aborted_write", 32'(mem[15'h0300]), 32'(ref_mem[15'h0300]));
    cpu_rd = 1'b0;
    step(); step();

    checkOutput("bus_conflicts", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
